// File: rtl/alu_param_seq.sv
// Sequential ALU: single-cycle add/sub/logic/compare plus iterative shift-add multiply and
// restoring divide behind a start/done handshake. Define ALU_SIGNED_EN for signed MUL/DIV/SLT.
module alu_param_seq #(
    parameter int WIDTH    = 16,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ALU_SIGNED_EN
    input  logic             op_signed,
`endif
    output logic [WIDTH-1:0] result_low,
    output logic [WIDTH-1:0] result_high,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_MUL, S_DIV, S_FIX, S_FIN
    } state_t;

`ifdef ALU_SIGNED_EN
    localparam state_t ITER_DONE = S_FIX;
`else
    localparam state_t ITER_DONE = S_FIN;
`endif

    state_t state, state_next;

    logic             sgn_in;
    logic             accept, load_result;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [WIDTH-1:0] op_a, op_b, opnd, hi, lo;
    logic [2:0]       op_code;
    logic             op_sgn, neg_q, neg_r;
    logic [CW-1:0]    cnt;

`ifdef ALU_SIGNED_EN
    assign sgn_in = op_signed;
`else
    assign sgn_in = 1'b0;
`endif

    // Handshake: start is a request taken only in IDLE (accept); done is a one-cycle
    // response whose results stay stable until the following done.
    assign accept = (state == S_IDLE) && start;
    assign a_neg  = sgn_in & a[WIDTH-1];
    assign b_neg  = sgn_in & b[WIDTH-1];
    assign mag_a  = a_neg ? (~a + 1'b1) : a;
    assign mag_b  = b_neg ? (~b + 1'b1) : b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (opcode)
                        OP_MUL:  state_next = S_MUL;
                        OP_DIV:  state_next = (b == '0) ? S_EXEC : S_DIV;
                        default: state_next = S_EXEC;
                    endcase
                end
            end
            S_MUL:   if (cnt == MUL_LAST) state_next = ITER_DONE;
            S_DIV:   if (cnt == DIV_LAST) state_next = ITER_DONE;
            S_FIX:   state_next = S_FIN;
            S_EXEC:  state_next = S_IDLE;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        load_result = (state == S_EXEC) || (state == S_FIN);
    end

    // Single-cycle results, computed from the latched operands.
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [WIDTH-1:0] exec_low, exec_high;
    logic             lt;

    always_comb begin
        sum_ext   = {1'b0, op_a} + {1'b0, op_b};
        diff_ext  = {1'b0, op_a} - {1'b0, op_b};
        lt        = op_sgn ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);
        exec_low  = '0;
        exec_high = '0;
        case (op_code)
            OP_ADD: begin
                exec_low  = sum_ext[WIDTH-1:0];
                exec_high = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH]};
            end
            OP_SUB: begin
                exec_low  = diff_ext[WIDTH-1:0];
                exec_high = {WIDTH{diff_ext[WIDTH]}};
            end
            OP_DIV: begin
                exec_low  = '1;
                exec_high = op_a;
            end
            OP_AND:  exec_low = op_a & op_b;
            OP_OR:   exec_low = op_a | op_b;
            OP_XOR:  exec_low = op_a ^ op_b;
            OP_SLT:  exec_low = {{(WIDTH-1){1'b0}}, lt};
            default: exec_low = '0;
        endcase
    end

    // Multiply step: hi accumulates, lo shifts the multiplier out and product bits in.
    logic [MUL_STEP-1:0]         mul_digit;
    logic [WIDTH+MUL_STEP-1:0]   mul_partial, mul_sum;
    logic [2*WIDTH+MUL_STEP-1:0] mul_wide;
    logic [WIDTH-1:0]            mul_hi_next, mul_lo_next;

    always_comb begin
        mul_digit   = lo[MUL_STEP-1:0];
        mul_partial = {{MUL_STEP{1'b0}}, opnd} * {{WIDTH{1'b0}}, mul_digit};
        mul_sum     = {{MUL_STEP{1'b0}}, hi} + mul_partial;
        mul_wide    = {mul_sum, lo};
        mul_hi_next = mul_wide[2*WIDTH+MUL_STEP-1:WIDTH+MUL_STEP];
        mul_lo_next = mul_wide[WIDTH+MUL_STEP-1:MUL_STEP];
    end

    // Restoring divide step: hi is the partial remainder, lo shifts dividend out / quotient in.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_trial;
    logic [WIDTH-1:0] div_rem_next, div_q_next;

    always_comb begin
        div_shift = {hi, lo[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opnd};
        if (!div_trial[WIDTH+1]) begin
            div_rem_next = div_trial[WIDTH-1:0];
            div_q_next   = {lo[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_next = div_shift[WIDTH-1:0];
            div_q_next   = {lo[WIDTH-2:0], 1'b0};
        end
    end

    logic [2*WIDTH-1:0] prod_neg;
    assign prod_neg = ~{hi, lo} + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a        <= '0;
            op_b        <= '0;
            op_code     <= '0;
            op_sgn      <= 1'b0;
            opnd        <= '0;
            hi          <= '0;
            lo          <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            result_low  <= '0;
            result_high <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= load_result;
            if (accept) begin
                op_a        <= a;
                op_b        <= b;
                op_code     <= opcode;
                op_sgn      <= sgn_in;
                div_by_zero <= 1'b0;
                cnt         <= '0;
                neg_q       <= a_neg ^ b_neg;
                neg_r       <= a_neg;
                hi          <= '0;
                if (opcode == OP_MUL) begin
                    opnd <= mag_a;
                    lo   <= mag_b;
                end else begin
                    opnd <= mag_b;
                    lo   <= mag_a;
                end
            end
            case (state)
                S_MUL: begin
                    hi  <= mul_hi_next;
                    lo  <= mul_lo_next;
                    cnt <= cnt + 1'b1;
                end
                S_DIV: begin
                    hi  <= div_rem_next;
                    lo  <= div_q_next;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (op_code == OP_MUL) begin
                        if (neg_q) {hi, lo} <= prod_neg;
                    end else begin
                        if (neg_q) lo <= ~lo + 1'b1;
                        if (neg_r) hi <= ~hi + 1'b1;
                    end
                end
                S_EXEC: begin
                    result_low  <= exec_low;
                    result_high <= exec_high;
                    if (op_code == OP_DIV) div_by_zero <= 1'b1;
                end
                S_FIN: begin
                    result_low  <= lo;
                    result_high <= hi;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_param_seq.sv
// Directed bench for alu_param_seq (default build): drivers push expected results with their
// done cycle; a negedge monitor pops and compares each done pulse and checks hold-while-busy.
module tb_alu_param_seq;

    localparam int W  = 16;
    localparam int EW = 16 + 1 + 2 * W;  // {done_cycle, dbz, high, low}

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   opcode;
    logic [W-1:0] a, b;
    logic [W-1:0] result_low, result_high;
    logic         busy, done, div_by_zero;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e;
    logic [W-1:0]  hold_low  = '0;
    logic [W-1:0]  hold_high = '0;
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    alu_param_seq #(.WIDTH(W), .MUL_STEP(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opcode      (opcode),
        .a           (a),
        .b           (b),
        .result_low  (result_low),
        .result_high (result_high),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            hold_low  = '0;
            hold_high = '0;
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done high with nothing pending (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", W'(cyc), e[EW-1:2*W+1]);
                check("result_low", result_low, e[W-1:0]);
                check("result_high", result_high, e[2*W-1:W]);
                check("div_by_zero", {15'b0, div_by_zero}, {15'b0, e[2*W]});
                check("busy_at_done", {15'b0, busy}, 16'd0);
                hold_low  = e[W-1:0];
                hold_high = e[2*W-1:W];
            end
        end else if (reset && busy) begin
            check("hold_low", result_low, hold_low);
            check("hold_high", result_high, hold_high);
        end
    end

    // drivers
    task automatic issue(input logic [2:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] elow, input logic [W-1:0] ehigh,
                         input logic edbz, input int lat);
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        a      = ia;
        b      = ib;
        @(posedge clk);
        #1;
        exp_q.push_back({16'(cyc + lat), edbz, ehigh, elow});
        check("busy_after_start", {15'b0, busy}, 16'd1);
        check("dbz_cleared_at_start", {15'b0, div_by_zero}, 16'd0);
        start = 1'b0;
        a     = W'($urandom_range(0, 65535));
        b     = W'($urandom_range(0, 65535));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL done_timeout: %0d results pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        opcode = '0;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        check("reset_low", result_low, 16'h0000);
        check("reset_high", result_high, 16'h0000);
        check("reset_busy", {15'b0, busy}, 16'd0);
        check("reset_done", {15'b0, done}, 16'd0);
        check("reset_dbz", {15'b0, div_by_zero}, 16'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // single-cycle ops
        issue(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1); wait_idle();
        issue(OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 16'hFFFF, 1'b0, 1); wait_idle();
        issue(OP_SUB, 16'h0005, 16'h0003, 16'h0002, 16'h0000, 1'b0, 1); wait_idle();
        issue(OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 1'b0, 1); wait_idle();
        issue(OP_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC, 16'h0000, 1'b0, 1); wait_idle();
        issue(OP_XOR, 16'hF0F0, 16'h3C3C, 16'hCCCC, 16'h0000, 1'b0, 1); wait_idle();
        issue(OP_SLT, 16'h0003, 16'h0005, 16'h0001, 16'h0000, 1'b0, 1); wait_idle();
        issue(OP_SLT, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1); wait_idle();
        issue(OP_SLT, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1); wait_idle();

        // start in the done cycle is accepted
        issue(OP_ADD, 16'h1234, 16'h4321, 16'h5555, 16'h0000, 1'b0, 1);
        @(posedge clk);
        #1;
        check("done_window", {15'b0, done}, 16'd1);
        issue(OP_SUB, 16'h1000, 16'h0001, 16'h0FFF, 16'h0000, 1'b0, 1);
        wait_idle();

        // multiply
        issue(OP_MUL, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 17); wait_idle();
        issue(OP_MUL, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17); wait_idle();

        // divide, including divide by zero and flag clearing
        issue(OP_DIV, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 17); wait_idle();
        issue(OP_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17); wait_idle();
        issue(OP_DIV, 16'h0003, 16'h0010, 16'h0000, 16'h0003, 1'b0, 17); wait_idle();
        issue(OP_DIV, 16'h0064, 16'h0000, 16'hFFFF, 16'h0064, 1'b1, 1);  wait_idle();
        check("dbz_holds", {15'b0, div_by_zero}, 16'd1);
        issue(OP_ADD, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 1'b0, 1);  wait_idle();

        // start pulses with new operands while MUL is busy are ignored
        issue(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start  = 1'b1;
            opcode = OP_ADD;
            a      = W'($urandom_range(0, 65535));
            b      = W'($urandom_range(0, 65535));
            @(negedge clk);
            start  = 1'b0;
        end
        wait_idle();
        repeat (4) @(negedge clk);

        // reset in the middle of a divide aborts it
        issue(OP_DIV, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 17);
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("midreset_low", result_low, 16'h0000);
        check("midreset_high", result_high, 16'h0000);
        check("midreset_busy", {15'b0, busy}, 16'd0);
        check("midreset_done", {15'b0, done}, 16'd0);
        check("midreset_dbz", {15'b0, div_by_zero}, 16'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        issue(OP_DIV, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 17); wait_idle();
        issue(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17); wait_idle();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
